barrel_referee: RTL

- Game-side controller at the other end of the barrel sprite's start/over interface.
- Drives the barrel's start and over inputs, and consumes the barrel's x, y and motion state alongside the player position.
- Detects player/barrel collisions, awards points for clean jumps over a barrel, tracks lives, and sequences arming, hit recovery and game over.
- Sits between the menu/top-level game FSM and one barrel instance; runs on the same game clock as the barrel.

---
 rtl/barrel_referee.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/barrel_referee.sv
// Referee for one barrel sprite: collisions, jump-over scoring,
// lives, and the arm / play / hit / game-over sequence.
module barrel_referee #(
    parameter int BARREL_W    = 32,
    parameter int BARREL_H    = 24,
    parameter int PLAYER_W    = 24,
    parameter int PLAYER_H    = 32,
    parameter int JUMP_WINDOW = 40,
    parameter int ARM_DELAY   = 60,
    parameter int HIT_HOLD    = 120,
    parameter int LIVES_INIT  = 3,
    parameter int JUMP_POINTS = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        game_start,
    input  logic [9:0]  player_x,
    input  logic [8:0]  player_y,
    input  logic        player_jumping,
    input  logic [9:0]  barrel_x,
    input  logic [8:0]  barrel_y,
    input  logic [1:0]  barrel_state,
    output logic        barrel_start,
    output logic        barrel_over,
    output logic [15:0] score,
    output logic [1:0]  lives,
    output logic [2:0]  phase,
    output logic        game_over
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARMING   = 3'd1,
        PLAY     = 3'd2,
        HIT      = 3'd3,
        GAMEOVER = 3'd4
    } phase_t;

    logic [1:0]  rst_sync;
    logic        rst_int;

    phase_t      state, state_nx;
    logic [15:0] cnt, cnt_nx;
    logic        start_nx;
    logic        over_nx;
    logic        game_over_nx;
    logic [15:0] score_nx;
    logic [1:0]  lives_nx;
    logic        pending, pending_nx;
    logic        hit_q;
    logic        ovh_prev;

    logic [10:0] player_r;
    logic [10:0] barrel_r;
    logic [9:0]  player_b;
    logic [9:0]  barrel_b;
    logic [9:0]  gap;
    logic        overlap_h;
    logic        overlap_v;
    logic        coincide;
    logic        jump_now;
    logic        fall;
    logic [16:0] score_sum;
    logic [15:0] score_sat;

    // Reset asserts at once, releases two clocks after rst rises
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync <= 2'b00;
        else      rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_int = rst_sync[1];

    assign player_r  = {1'b0, player_x} + 11'(PLAYER_W);
    assign barrel_r  = {1'b0, barrel_x} + 11'(BARREL_W);
    assign player_b  = {1'b0, player_y} + 10'(PLAYER_H);
    assign barrel_b  = {1'b0, barrel_y} + 10'(BARREL_H);
    assign overlap_h = ({1'b0, barrel_x} < player_r)
                     && (barrel_r > {1'b0, player_x});
    assign overlap_v = ({1'b0, barrel_y} < player_b)
                     && (barrel_b > {1'b0, player_y});
    assign coincide  = overlap_h && overlap_v
                     && (barrel_state != 2'b00);
    assign gap       = {1'b0, barrel_y} - player_b;
    assign jump_now  = player_jumping && overlap_h
                     && ({1'b0, barrel_y} >= player_b)
                     && (gap <= 10'(JUMP_WINDOW));
    assign fall      = ovh_prev && !overlap_h;
    assign score_sum = {1'b0, score} + 17'(JUMP_POINTS);
    assign score_sat = score_sum[16] ? 16'hFFFF : score_sum[15:0];

    // State, counters and all registered outputs
    always_ff @(posedge clk or negedge rst_int) begin
        if (!rst_int) begin
            state        <= IDLE;
            cnt          <= '0;
            barrel_start <= 1'b0;
            barrel_over  <= 1'b1;
            score        <= '0;
            lives        <= 2'(LIVES_INIT);
            game_over    <= 1'b0;
            pending      <= 1'b0;
            hit_q        <= 1'b0;
            ovh_prev     <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            barrel_start <= start_nx;
            barrel_over  <= over_nx;
            score        <= score_nx;
            lives        <= lives_nx;
            game_over    <= game_over_nx;
            pending      <= pending_nx;
            hit_q        <= coincide;
            ovh_prev     <= overlap_h;
        end
    end

    // Next-state, counter and output decode
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        start_nx   = barrel_start;
        score_nx   = score;
        lives_nx   = lives;
        pending_nx = pending;
        unique case (state)
            IDLE, GAMEOVER: begin
                if (game_start) begin
                    score_nx = '0;
                    lives_nx = 2'(LIVES_INIT);
                    cnt_nx   = '0;
                    start_nx = 1'b0;
                    state_nx = ARMING;
                end
            end
            ARMING: begin
                if (!barrel_start) begin
                    if (cnt == 16'(ARM_DELAY - 1)) start_nx = 1'b1;
                    else                           cnt_nx = cnt + 16'd1;
                end else if (barrel_state == 2'b01) begin
                    start_nx   = 1'b0;
                    pending_nx = 1'b0;
                    state_nx   = PLAY;
                end
            end
            PLAY: begin
                if (hit_q) begin
                    pending_nx = 1'b0;
                    lives_nx   = (lives != 2'd0) ? lives - 2'd1 : 2'd0;
                    cnt_nx     = 16'(HIT_HOLD);
                    state_nx   = (lives <= 2'd1) ? GAMEOVER : HIT;
                end else begin
                    if (fall && pending) begin
                        score_nx   = score_sat;
                        pending_nx = 1'b0;
                    end
                    if (jump_now) pending_nx = 1'b1;
                end
            end
            HIT: begin
                if (cnt != 16'd0)                cnt_nx = cnt - 16'd1;
                else if (barrel_state == 2'b00) state_nx = ARMING;
            end
            default: state_nx = IDLE;
        endcase
        over_nx      = (state_nx == IDLE) || (state_nx == HIT)
                     || (state_nx == GAMEOVER);
        game_over_nx = (state_nx == GAMEOVER);
    end

    assign phase = state;

endmodule
